// File: rtl/spike_stim_encoder.sv
// spike_stim_encoder: buffers (a,b) stimulus pairs in a FIFO and emits them as paced single-cycle valid pulses
//   parameters: DATA_W operand width, DEPTH FIFO entries (power of two, >= 2), INT_W interval width
//   clk, rst (async, active-high)
//   enable, pause, cfg_interval          emission control
//   stim_valid, stim_ready, stim_a/b     upstream push interface
//   spike_in_data_a/b, spike_in_valid    registered grid outputs
//   fifo_level, underrun                 status
//   sent_count                           emission counter, present only with SPIKE_ENC_STATS_EN
module spike_stim_encoder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int INT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     pause,
    input  logic [INT_W-1:0]         cfg_interval,
    input  logic                     stim_valid,
    output logic                     stim_ready,
    input  logic [DATA_W-1:0]        stim_a,
    input  logic [DATA_W-1:0]        stim_b,
    output logic [DATA_W-1:0]        spike_in_data_a,
    output logic [DATA_W-1:0]        spike_in_data_b,
    output logic                     spike_in_valid,
    output logic [$clog2(DEPTH):0]   fifo_level,
`ifdef SPIKE_ENC_STATS_EN
    output logic [15:0]              sent_count,
`endif
    output logic                     underrun
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, GAP} state_t;

    state_t           state;
    logic [INT_W-1:0] gap_cnt;
    logic [AW:0]      wptr, rptr;
    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic             full, empty, push, emit;
    logic [INT_W-1:0] ival_m1;

    assign fifo_level = wptr - rptr;
    assign full       = fifo_level == (AW+1)'(DEPTH);
    assign empty      = fifo_level == '0;
    assign stim_ready = !full;
    assign push       = stim_valid && !full;
    assign emit       = state == ARMED && enable && !pause && !empty;
    // interval 0 behaves as 1, so the reload value never underflows
    assign ival_m1    = cfg_interval == '0 ? '0 : cfg_interval - INT_W'(1);

    // storage needs no reset: reset clears the pointers, which discards the contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wptr[AW-1:0]] <= stim_a;
            mem_b[wptr[AW-1:0]] <= stim_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            wptr            <= '0;
            rptr            <= '0;
            spike_in_valid  <= 1'b0;
            spike_in_data_a <= '0;
            spike_in_data_b <= '0;
            underrun        <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + (AW+1)'(1);
            if (emit) begin
                rptr            <= rptr + (AW+1)'(1);
                spike_in_data_a <= mem_a[rptr[AW-1:0]];
                spike_in_data_b <= mem_b[rptr[AW-1:0]];
            end
            spike_in_valid <= emit;
            if (!enable) begin
                state    <= IDLE;
                gap_cnt  <= '0;
                underrun <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (!pause && !empty) begin
                            gap_cnt <= ival_m1;
                            state   <= ival_m1 == '0 ? ARMED : GAP;
                        end else if (!pause) begin
                            underrun <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (!pause) begin
                            if (gap_cnt != '0)
                                gap_cnt <= gap_cnt - INT_W'(1);
                            state <= gap_cnt <= INT_W'(1) ? ARMED : GAP;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPIKE_ENC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sent_count <= '0;
        else if (!enable)
            sent_count <= '0;
        else if (emit)
            sent_count <= sent_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_spike_stim_encoder.sv
// tb_spike_stim_encoder: directed and randomized checks of spike_stim_encoder against a queue/deadline model
module tb_spike_stim_encoder;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int INT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              pause = 1'b0;
    logic [INT_W-1:0]  cfg_interval = '0;
    logic              stim_valid = 1'b0;
    logic              stim_ready;
    logic [DATA_W-1:0] stim_a = '0;
    logic [DATA_W-1:0] stim_b = '0;
    logic [DATA_W-1:0] spike_in_data_a;
    logic [DATA_W-1:0] spike_in_data_b;
    logic              spike_in_valid;
    logic [$clog2(DEPTH):0] fifo_level;
    logic              underrun;
`ifdef SPIKE_ENC_STATS_EN
    logic [15:0]       sent_count;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spike_stim_encoder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INT_W(INT_W)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .pause(pause),
        .cfg_interval(cfg_interval),
        .stim_valid(stim_valid),
        .stim_ready(stim_ready),
        .stim_a(stim_a),
        .stim_b(stim_b),
        .spike_in_data_a(spike_in_data_a),
        .spike_in_data_b(spike_in_data_b),
        .spike_in_valid(spike_in_valid),
        .fifo_level(fifo_level),
`ifdef SPIKE_ENC_STATS_EN
        .sent_count(sent_count),
`endif
        .underrun(underrun)
    );

    // Reference model: a queue of pending pairs plus the earliest edge index at
    // which the next emission is allowed; pauses push that deadline back.
    logic [DATA_W-1:0] q_a[$];
    logic [DATA_W-1:0] q_b[$];
    int k = 0;
    int en_edges = 0;
    int ready_at = 0;
    logic m_valid = 0;
    logic m_under = 0;
    logic [DATA_W-1:0] m_a = 0;
    logic [DATA_W-1:0] m_b = 0;
    int m_sent = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(spike_in_valid), 32'(m_valid));
        chk("data_a", 32'(spike_in_data_a), 32'(m_a));
        chk("data_b", 32'(spike_in_data_b), 32'(m_b));
        chk("level", 32'(fifo_level), 32'(q_a.size()));
        chk("ready", 32'(stim_ready), 32'(q_a.size() < DEPTH));
        chk("underrun", 32'(underrun), 32'(m_under));
`ifdef SPIKE_ENC_STATS_EN
        chk("sent", 32'(sent_count), 32'(m_sent));
`endif
    endtask

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        en_edges = 0;
        m_valid = 0;
        m_under = 0;
        m_a = 0;
        m_b = 0;
        m_sent = 0;
    endtask

    task automatic tick();
        int sz;
        @(posedge clk);
        k++;
        sz = q_a.size();
        m_valid = 0;
        if (!enable) begin
            en_edges = 0;
            m_under = 0;
            m_sent = 0;
        end else if (en_edges == 0) begin
            en_edges = 1;
            ready_at = k + 1;
        end else if (pause) begin
            if (k < ready_at) ready_at++;
        end else if (k >= ready_at) begin
            if (sz > 0) begin
                m_valid = 1;
                m_a = q_a.pop_front();
                m_b = q_b.pop_front();
                ready_at = k + (cfg_interval == 0 ? 1 : int'(cfg_interval));
                m_sent = (m_sent + 1) % 65536;
            end else begin
                m_under = 1;
            end
        end
        if (stim_valid && sz < DEPTH) begin
            q_a.push_back(stim_a);
            q_b.push_back(stim_b);
        end
        #1;
        check_all();
    endtask

    task automatic push_tick(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        stim_valid = 1'b1;
        stim_a = a;
        stim_b = b;
        tick();
        stim_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // power-on reset
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;

        // single pair, interval 4
        enable = 1'b1;
        cfg_interval = 8'd4;
        idle(2);
        push_tick(8'd10, 8'd5);
        idle(6);

        // spacing 3, then back-to-back with interval 0
        cfg_interval = 8'd3;
        for (int i = 0; i < 4; i++) push_tick(8'(16 + i), 8'(32 + i));
        idle(14);
        cfg_interval = 8'd0;
        for (int i = 0; i < 4; i++) push_tick(8'(48 + i), 8'(64 + i));
        idle(6);

        // backpressure with emission disabled, then drain
        enable = 1'b0;
        for (int i = 0; i < 5; i++) push_tick(8'(80 + i), 8'(96 + i));
        chk("full_ready", 32'(stim_ready), 32'(0));
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        enable = 1'b1;
        idle(10);

        // pause during gap
        cfg_interval = 8'd2;
        push_tick(8'd1, 8'd2);
        push_tick(8'd3, 8'd4);
        for (int i = 0; i < 20 && !m_valid; i++) tick();
        pause = 1'b1;
        idle(3);
        pause = 1'b0;
        idle(6);

        // underrun set, sticky across push, cleared by enable low
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        idle(2);
        chk("underrun_set", 32'(underrun), 32'(1));
        push_tick(8'd7, 8'd8);
        idle(2);
        enable = 1'b0;
        idle(1);
        chk("underrun_clr", 32'(underrun), 32'(0));
        enable = 1'b1;

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 37 == 0) cfg_interval = 8'($urandom_range(0, 5));
            enable = $urandom_range(0, 24) != 0;
            pause = $urandom_range(0, 9) == 0;
            stim_valid = $urandom_range(0, 1) == 1;
            stim_a = 8'($urandom);
            stim_b = 8'($urandom);
            tick();
        end
        stim_valid = 1'b0;
        pause = 1'b0;

        // asynchronous reset mid-gap with entries queued
        enable = 1'b1;
        cfg_interval = 8'd5;
        idle(2);
        for (int i = 0; i < 3; i++) push_tick(8'(200 + i), 8'(220 + i));
        idle(1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);
        push_tick(8'd99, 8'd77);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
